// File: rtl/audio_sample_conditioner_if.sv
// rtl/audio_sample_conditioner_if.sv - sample input controls and held stereo sample outputs
interface audio_sample_conditioner_if;
  logic               in_ce;
  logic signed [17:0] audio_l;
  logic signed [17:0] audio_r;
  logic [1:0]         volume;
  logic               mute;
  logic               clip_clr;
  logic signed [15:0] sample_l;
  logic signed [15:0] sample_r;
  logic               sample_valid;
  logic               clip_l;
  logic               clip_r;

  modport master (
    output in_ce, audio_l, audio_r, volume, mute, clip_clr,
    input  sample_l, sample_r, sample_valid, clip_l, clip_r
  );

  modport slave (
    input  in_ce, audio_l, audio_r, volume, mute, clip_clr,
    output sample_l, sample_r, sample_valid, clip_l, clip_r
  );
endinterface

// File: rtl/audio_sample_conditioner.sv
// rtl/audio_sample_conditioner.sv - IIR low-pass, 48 kHz decimation, 18->16 bit saturation, volume/mute
module audio_sample_conditioner #(
  parameter int CLK_HZ     = 31527954,
  parameter int AUDIO_HZ   = 48000,
  parameter int FILT_SHIFT = 4
) (
  input logic                       clk,
  input logic                       reset,
  audio_sample_conditioner_if.slave bus
);
  localparam int YW = 18 + FILT_SHIFT;
  localparam int IW = 19 + FILT_SHIFT;
  localparam logic [32:0] INC = 33'(AUDIO_HZ);
  localparam logic [32:0] LIM = 33'(CLK_HZ);
  localparam logic signed [YW-1:0] POS_MAX = YW'(32767);
  localparam logic signed [YW-1:0] NEG_MIN = -YW'(32768);

  logic [31:0]          acc_q, acc_d;
  logic [32:0]          acc_sum;
  logic                 tick_q, tick_d;
  logic signed [YW-1:0] yl_q, yl_d, yr_q, yr_d;
  logic                 s1_valid_q, s1_valid_d;
  logic signed [15:0]   s1_l_q, s1_l_d, s1_r_q, s1_r_d;
  logic                 sample_valid_q, sample_valid_d;
  logic signed [15:0]   sample_l_q, sample_l_d, sample_r_q, sample_r_d;
  logic                 clip_l_q, clip_l_d, clip_r_q, clip_r_d;
  logic [16:0]          sat_l, sat_r;

  // y + x - (y >>> FILT_SHIFT), evaluated one bit wider than the state
  function automatic logic signed [YW-1:0] filt_step(input logic signed [YW-1:0] y,
                                                      input logic signed [17:0] x);
    logic signed [YW-1:0] y_sh;
    logic signed [IW-1:0] y_ext, x_ext, sh_ext;
    y_sh   = y >>> FILT_SHIFT;
    y_ext  = {y[YW-1], y};
    x_ext  = {{(IW-18){x[17]}}, x};
    sh_ext = {y_sh[YW-1], y_sh};
    return YW'(y_ext + x_ext - sh_ext);
  endfunction

  // Returns {clipped, value}; (y >>> FILT_SHIFT) >>> 1 collapses to one floor shift
  function automatic logic [16:0] sat16(input logic signed [YW-1:0] y);
    logic signed [YW-1:0] h;
    h = y >>> (FILT_SHIFT + 1);
    if (h > POS_MAX)      return {1'b1, 16'h7fff};
    else if (h < NEG_MIN) return {1'b1, 16'h8000};
    else                  return {1'b0, h[15:0]};
  endfunction

  function automatic logic signed [15:0] apply_vol(input logic signed [15:0] s,
                                                   input logic [1:0] vol, input logic mute);
    if (mute) return '0;
    case (vol)
      2'd3:    return s;
      2'd2:    return s >>> 1;
      2'd1:    return s >>> 2;
      default: return '0;
    endcase
  endfunction

  always_comb begin
    acc_sum        = {1'b0, acc_q} + INC;
    acc_d          = acc_sum[31:0];
    tick_d         = 1'b0;
    yl_d           = yl_q;
    yr_d           = yr_q;
    sat_l          = sat16(yl_q);
    sat_r          = sat16(yr_q);
    s1_valid_d     = tick_q;
    s1_l_d         = s1_l_q;
    s1_r_d         = s1_r_q;
    sample_valid_d = 1'b0;
    sample_l_d     = sample_l_q;
    sample_r_d     = sample_r_q;
    clip_l_d       = bus.clip_clr ? 1'b0 : clip_l_q;
    clip_r_d       = bus.clip_clr ? 1'b0 : clip_r_q;

    if (acc_sum >= LIM) begin
      acc_d  = 32'(acc_sum - LIM);
      tick_d = 1'b1;
    end
    if (bus.in_ce) begin
      yl_d = filt_step(yl_q, bus.audio_l);
      yr_d = filt_step(yr_q, bus.audio_r);
    end
    // Stage 1 reads the filter state before this cycle's in_ce update; a new clip beats clip_clr
    if (tick_q) begin
      s1_l_d = sat_l[15:0];
      s1_r_d = sat_r[15:0];
      if (sat_l[16]) clip_l_d = 1'b1;
      if (sat_r[16]) clip_r_d = 1'b1;
    end
    if (s1_valid_q) begin
      sample_l_d     = apply_vol(s1_l_q, bus.volume, bus.mute);
      sample_r_d     = apply_vol(s1_r_q, bus.volume, bus.mute);
      sample_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q          <= '0;
      tick_q         <= 1'b0;
      yl_q           <= '0;
      yr_q           <= '0;
      s1_valid_q     <= 1'b0;
      s1_l_q         <= '0;
      s1_r_q         <= '0;
      sample_valid_q <= 1'b0;
      sample_l_q     <= '0;
      sample_r_q     <= '0;
      clip_l_q       <= 1'b0;
      clip_r_q       <= 1'b0;
    end else begin
      acc_q          <= acc_d;
      tick_q         <= tick_d;
      yl_q           <= yl_d;
      yr_q           <= yr_d;
      s1_valid_q     <= s1_valid_d;
      s1_l_q         <= s1_l_d;
      s1_r_q         <= s1_r_d;
      sample_valid_q <= sample_valid_d;
      sample_l_q     <= sample_l_d;
      sample_r_q     <= sample_r_d;
      clip_l_q       <= clip_l_d;
      clip_r_q       <= clip_r_d;
    end
  end

  assign bus.sample_l     = sample_l_q;
  assign bus.sample_r     = sample_r_q;
  assign bus.sample_valid = sample_valid_q;
  assign bus.clip_l       = clip_l_q;
  assign bus.clip_r       = clip_r_q;
endmodule

// File: tb/tb_audio_sample_conditioner.sv
// tb/tb_audio_sample_conditioner.sv - directed vector bench for audio_sample_conditioner
module tb_audio_sample_conditioner;
  logic clk = 1'b0;
  logic reset;

  audio_sample_conditioner_if bus();

  audio_sample_conditioner dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         al;
    int         ar;
    logic [1:0] vol;
    bit         mute;
    int         el;
    int         er;
    bit         ecl;
    bit         ecr;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Samples at negedges; cycles = negedges stepped until sample_valid seen
  task automatic wait_valid(input int budget, output int cycles, output bit ok);
    cycles = 0;
    ok     = 1'b0;
    while (cycles < budget && !ok) begin
      @(negedge clk);
      cycles++;
      if (bus.sample_valid) ok = 1'b1;
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout: no sample_valid within %0d cycles", budget);
    end
  endtask

  task automatic skip_valids(input int n);
    int c;
    bit ok;
    for (int i = 0; i < n; i++) wait_valid(1500, c, ok);
  endtask

  vec_t vecs[12];
  int   c;
  bit   ok;
  longint cyc;
  longint exp_cyc;
  int   prev;
  bit   seen;

  initial begin
    vecs[0]  = '{65536,        0, 2'd3, 1'b0,  32767,      0, 1'b1, 1'b0};
    vecs[1]  = '{0,      -131072, 2'd3, 1'b0,      0, -32768, 1'b0, 1'b1};
    vecs[2]  = '{4000,     -4000, 2'd3, 1'b0,   2000,  -2000, 1'b0, 1'b0};
    vecs[3]  = '{4000,     -4000, 2'd2, 1'b0,   1000,  -1000, 1'b0, 1'b0};
    vecs[4]  = '{4000,     -4000, 2'd1, 1'b0,    500,   -500, 1'b0, 1'b0};
    vecs[5]  = '{4000,     -4000, 2'd0, 1'b0,      0,      0, 1'b0, 1'b0};
    vecs[6]  = '{4000,     -4000, 2'd3, 1'b1,      0,      0, 1'b0, 1'b0};
    vecs[7]  = '{65535,   -65536, 2'd3, 1'b0,  32767, -32768, 1'b0, 1'b0};
    vecs[8]  = '{65537,   -65538, 2'd3, 1'b0,  32767, -32768, 1'b1, 1'b1};
    vecs[9]  = '{-1,          -3, 2'd3, 1'b0,     -1,     -2, 1'b0, 1'b0};
    vecs[10] = '{131071, -131072, 2'd1, 1'b0,   8191,  -8192, 1'b1, 1'b1};
    vecs[11] = '{-4000,     4000, 2'd2, 1'b0,  -1000,   1000, 1'b0, 1'b0};

    reset        = 1'b1;
    bus.in_ce    = 1'b1;
    bus.audio_l  = '0;
    bus.audio_r  = '0;
    bus.volume   = 2'd3;
    bus.mute     = 1'b0;
    bus.clip_clr = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_sample_l", bus.sample_l, 0);
    check("rst_sample_r", bus.sample_r, 0);
    check("rst_valid", bus.sample_valid, 0);
    check("rst_clip_l", bus.clip_l, 0);
    check("rst_clip_r", bus.clip_r, 0);

    // Cadence: n-th tick in cycle ceil(n*CLK_HZ/AUDIO_HZ)+1, valid two cycles later
    reset = 1'b0;
    cyc   = 1;
    for (int n = 1; n <= 20; n++) begin
      wait_valid(1500, c, ok);
      cyc     = cyc + c;
      exp_cyc = (longint'(n) * 31527954 + 47999) / 48000 + 3;
      check($sformatf("cadence_pulse%0d", n), int'(cyc), int'(exp_cyc));
      if (n == 1) begin
        @(negedge clk);
        cyc++;
        check("valid_one_cycle", bus.sample_valid, 0);
      end
    end

    for (int i = 0; i < 12; i++) begin
      bus.audio_l = 18'(vecs[i].al);
      bus.audio_r = 18'(vecs[i].ar);
      bus.volume  = vecs[i].vol;
      bus.mute    = vecs[i].mute;
      skip_valids(2);
      @(negedge clk);
      bus.clip_clr = 1'b1;
      @(negedge clk);
      bus.clip_clr = 1'b0;
      wait_valid(1500, c, ok);
      check($sformatf("vec%0d_sample_l", i), bus.sample_l, vecs[i].el);
      check($sformatf("vec%0d_sample_r", i), bus.sample_r, vecs[i].er);
      check($sformatf("vec%0d_clip_l", i), bus.clip_l, int'(vecs[i].ecl));
      check($sformatf("vec%0d_clip_r", i), bus.clip_r, int'(vecs[i].ecr));
    end

    // clip_clr held through a clipping tick: the set must win for one cycle
    bus.audio_l = 18'sd65536;
    bus.audio_r = '0;
    bus.volume  = 2'd3;
    skip_valids(2);
    @(negedge clk);
    bus.clip_clr = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 800 && !seen; i++) begin
      @(negedge clk);
      if (bus.clip_l) seen = 1'b1;
    end
    bus.clip_clr = 1'b0;
    check("clip_set_wins", int'(seen), 1);
    skip_valids(1);
    check("clip_after_set", bus.clip_l, 1);

    // Filter hold while in_ce=0, then monotonic recovery
    bus.audio_l = 18'sd4000;
    skip_valids(3);
    check("hold_settled", bus.sample_l, 2000);
    bus.in_ce   = 1'b0;
    bus.audio_l = -18'sd4000;
    for (int i = 0; i < 8; i++) begin
      wait_valid(1500, c, ok);
      check($sformatf("hold_%0d", i), bus.sample_l, 2000);
    end
    bus.in_ce = 1'b1;
    prev = 2000;
    for (int i = 0; i < 3; i++) begin
      wait_valid(1500, c, ok);
      check($sformatf("recover_mono_%0d", i), int'(bus.sample_l <= 16'(prev)), 1);
      prev = bus.sample_l;
    end
    check("recover_final", bus.sample_l, -2000);

    // Mid-run reset one cycle after a tick
    bus.audio_l = 18'sd65536;
    skip_valids(2);
    check("pre_reset_clip_l", bus.clip_l, 1);
    bus.audio_l = 18'sd4000;
    bus.audio_r = -18'sd4000;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("reset_clr_sample_l", bus.sample_l, 0);
    check("reset_clr_clip_l", bus.clip_l, 0);
    seen = 1'b0;
    for (int k = 2; k <= 659; k++) begin
      @(negedge clk);
      if (bus.sample_valid) seen = 1'b1;
    end
    check("no_early_valid", int'(seen), 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("inflight_discarded", bus.sample_valid, 0);
    check("inflight_sample_l", bus.sample_l, 0);
    check("inflight_sample_r", bus.sample_r, 0);
    wait_valid(700, c, ok);
    check("post_reset_first_valid", 1 + c, 660);
    check("post_reset_sample_l", bus.sample_l, 2000);
    check("post_reset_sample_r", bus.sample_r, -2000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
